// File: rtl/lvda_pio_sequencer.sv
// LVDA PIO address-decode sequencer: round-robin arbitration between the CPU and DCA ports,
// then a fixed SETUP/X3/W8/Y8 strobe sequence per granted command.
module lvda_pio_sequencer #(
    parameter int unsigned PHASE_CYC = 2
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       CPU_REQ,
    input  logic [4:0] CPU_ADDR,
    input  logic       CPU_RD,
    input  logic       DCA_REQ,
    input  logic [4:0] DCA_ADDR,
    input  logic       DCA_RD,
    output logic       CPU_ACK,
    output logic       DCA_ACK,
    output logic       ADV,
    output logic [4:0] ADR_DV,
    output logic [4:0] ADR_DVN,
    output logic       DARA,
    output logic       DARO,
    output logic       X3,
    output logic       W8,
    output logic       Y8,
    output logic       BUSY,
    output logic       GNT_DCA
);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StSetup,
        StX3,
        StW8,
        StY8,
        StRel
    } state_e;

    localparam logic [3:0] Reload = 4'(PHASE_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] addr_q, addr_d;
    logic       rd_q, rd_d;
    logic       gnt_q, gnt_d;
    logic       prio_q, prio_d;
    logic       win;

    logic       adv_q, adv_d;
    logic [4:0] dv_q, dv_d;
    logic [4:0] dvn_q, dvn_d;
    logic       dara_q, dara_d;
    logic       daro_q, daro_d;
    logic       x3_q, x3_d;
    logic       w8_q, w8_d;
    logic       y8_q, y8_d;
    logic       busy_q, busy_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       dca_ack_q, dca_ack_d;
    logic       strobe_on;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        win     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CPU_REQ || DCA_REQ) state_d = StArb;
            end
            StArb: begin
                // prio_q set means DCA wins a tie; it always points away from the last winner
                win     = DCA_REQ && (!CPU_REQ || prio_q);
                gnt_d   = win;
                prio_d  = !win;
                addr_d  = win ? DCA_ADDR : CPU_ADDR;
                rd_d    = win ? DCA_RD : CPU_RD;
                cnt_d   = Reload;
                state_d = StSetup;
            end
            StSetup, StX3, StW8, StY8: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = Reload;
                    case (state_q)
                        StSetup: state_d = StX3;
                        StX3:    state_d = StW8;
                        StW8:    state_d = StY8;
                        default: begin
                            state_d = StRel;
                            cnt_d   = 4'd0;
                        end
                    endcase
                end
            end
            StRel: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from next-state values and registered, so they align with the state.
    always_comb begin
        adv_d     = state_d inside {StSetup, StX3, StW8, StY8};
        strobe_on = state_d inside {StX3, StW8, StY8};
        dv_d      = adv_d ? addr_d : 5'd0;
        dvn_d     = adv_d ? ~addr_d : 5'd0;
        dara_d    = strobe_on && !rd_d;
        daro_d    = strobe_on && rd_d;
        x3_d      = state_d == StX3;
        w8_d      = state_d == StW8;
        y8_d      = state_d == StY8;
        busy_d    = state_d != StIdle;
        cpu_ack_d = (state_d == StRel) && !gnt_d;
        dca_ack_d = (state_d == StRel) && gnt_d;
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= 5'd0;
            rd_q      <= 1'b0;
            gnt_q     <= 1'b0;
            prio_q    <= 1'b0;
            adv_q     <= 1'b0;
            dv_q      <= 5'd0;
            dvn_q     <= 5'd0;
            dara_q    <= 1'b0;
            daro_q    <= 1'b0;
            x3_q      <= 1'b0;
            w8_q      <= 1'b0;
            y8_q      <= 1'b0;
            busy_q    <= 1'b0;
            cpu_ack_q <= 1'b0;
            dca_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            gnt_q     <= gnt_d;
            prio_q    <= prio_d;
            adv_q     <= adv_d;
            dv_q      <= dv_d;
            dvn_q     <= dvn_d;
            dara_q    <= dara_d;
            daro_q    <= daro_d;
            x3_q      <= x3_d;
            w8_q      <= w8_d;
            y8_q      <= y8_d;
            busy_q    <= busy_d;
            cpu_ack_q <= cpu_ack_d;
            dca_ack_q <= dca_ack_d;
        end
    end

    assign CPU_ACK = cpu_ack_q;
    assign DCA_ACK = dca_ack_q;
    assign ADV     = adv_q;
    assign ADR_DV  = dv_q;
    assign ADR_DVN = dvn_q;
    assign DARA    = dara_q;
    assign DARO    = daro_q;
    assign X3      = x3_q;
    assign W8      = w8_q;
    assign Y8      = y8_q;
    assign BUSY    = busy_q;
    assign GNT_DCA = gnt_q;

endmodule

// File: tb/tb_lvda_pio_sequencer.sv
// Directed bench for lvda_pio_sequencer (PHASE_CYC=2), plus per-cycle invariant checks on
// PHASE_CYC=1 and PHASE_CYC=15 instances driven by random requests.
module tb_lvda_pio_sequencer;

    localparam int P = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rst = 1'b0;
    logic       cpu_req = 1'b0, cpu_rd = 1'b0, dca_req = 1'b0, dca_rd = 1'b0;
    logic [4:0] cpu_addr = 5'd0, dca_addr = 5'd0;
    logic       cpu_ack, dca_ack, adv, dara, daro, x3, w8, y8, busy, gnt_dca;
    logic [4:0] adr_dv, adr_dvn;

    lvda_pio_sequencer #(.PHASE_CYC(P)) dut (
        .SIM_CLK(clk), .SIM_RST(rst),
        .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_RD(cpu_rd),
        .DCA_REQ(dca_req), .DCA_ADDR(dca_addr), .DCA_RD(dca_rd),
        .CPU_ACK(cpu_ack), .DCA_ACK(dca_ack), .ADV(adv), .ADR_DV(adr_dv), .ADR_DVN(adr_dvn),
        .DARA(dara), .DARO(daro), .X3(x3), .W8(w8), .Y8(y8), .BUSY(busy), .GNT_DCA(gnt_dca)
    );

    // Random-stimulus instances share one set of inputs.
    logic       r_cpu_req = 1'b0, r_cpu_rd = 1'b0, r_dca_req = 1'b0, r_dca_rd = 1'b0;
    logic [4:0] r_cpu_addr = 5'd0, r_dca_addr = 5'd0;
    logic       a_cack, a_dack, a_adv, a_dara, a_daro, a_x3, a_w8, a_y8, a_busy, a_gnt;
    logic       b_cack, b_dack, b_adv, b_dara, b_daro, b_x3, b_w8, b_y8, b_busy, b_gnt;
    logic [4:0] a_dv, a_dvn, b_dv, b_dvn;
    int         a_acks = 0, b_acks = 0;

    lvda_pio_sequencer #(.PHASE_CYC(1)) dut_p1 (
        .SIM_CLK(clk), .SIM_RST(rst),
        .CPU_REQ(r_cpu_req), .CPU_ADDR(r_cpu_addr), .CPU_RD(r_cpu_rd),
        .DCA_REQ(r_dca_req), .DCA_ADDR(r_dca_addr), .DCA_RD(r_dca_rd),
        .CPU_ACK(a_cack), .DCA_ACK(a_dack), .ADV(a_adv), .ADR_DV(a_dv), .ADR_DVN(a_dvn),
        .DARA(a_dara), .DARO(a_daro), .X3(a_x3), .W8(a_w8), .Y8(a_y8), .BUSY(a_busy),
        .GNT_DCA(a_gnt)
    );

    lvda_pio_sequencer #(.PHASE_CYC(15)) dut_p15 (
        .SIM_CLK(clk), .SIM_RST(rst),
        .CPU_REQ(r_cpu_req), .CPU_ADDR(r_cpu_addr), .CPU_RD(r_cpu_rd),
        .DCA_REQ(r_dca_req), .DCA_ADDR(r_dca_addr), .DCA_RD(r_dca_rd),
        .CPU_ACK(b_cack), .DCA_ACK(b_dack), .ADV(b_adv), .ADR_DV(b_dv), .ADR_DVN(b_dvn),
        .DARA(b_dara), .DARO(b_daro), .X3(b_x3), .W8(b_w8), .Y8(b_y8), .BUSY(b_busy),
        .GNT_DCA(b_gnt)
    );

    wire [19:0] obs = {cpu_ack, dca_ack, adv, adr_dv, adr_dvn, dara, daro, x3, w8, y8, busy,
                       gnt_dca};

    // Phase code for cycle k after the request edge: 0 idle, 1 ARB, 2 SETUP, 3 X3, 4 W8,
    // 5 Y8, 6 REL.
    function automatic int phase_of(int k);
        if (k == 1) return 1;
        if (k >= 2 && k <= 1 + 4 * P) return 2 + (k - 2) / P;
        if (k == 2 + 4 * P) return 6;
        return 0;
    endfunction

    function automatic logic [19:0] expv(int ph, logic [4:0] a, logic rd, logic dca, logic gnt);
        logic en_adv, en_str;
        en_adv = (ph >= 2) && (ph <= 5);
        en_str = (ph >= 3) && (ph <= 5);
        return {ph == 6 && !dca, ph == 6 && dca, en_adv, en_adv ? a : 5'd0,
                en_adv ? ~a : 5'd0, en_str && !rd, en_str && rd, ph == 3, ph == 4, ph == 5,
                ph != 0, gnt};
    endfunction

    task automatic check(input string tag, input logic [19:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks cycles first..last of one command; optionally perturbs inputs at cycle mut and
    // drops the requests in drop (bit0 CPU, bit1 DCA) once ACK is seen.
    task automatic watch(input string tag, input int first, input int last, input logic [4:0] a,
                         input logic rd, input logic dca, input logic prev, input int mut,
                         input logic [1:0] drop);
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("%s k%0d", tag, k),
                  expv(phase_of(k), a, rd, dca, (k == 1) ? prev : dca));
            if (k == mut) begin
                dca_addr = 5'h1f;
                dca_rd   = ~dca_rd;
                cpu_addr = 5'h1f;
                cpu_rd   = ~cpu_rd;
            end
            if (k == 2 + 4 * P) begin
                if (drop[0]) cpu_req = 1'b0;
                if (drop[1]) dca_req = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst     = 1'b0;
        cpu_req = 1'b0;
        dca_req = 1'b0;
        @(negedge clk);
        check(tag, 20'd0);
        rst = 1'b1;
    endtask

    // Random stimulus and per-cycle invariants for the PHASE_CYC=1/15 instances.
    initial begin
        forever begin
            @(negedge clk);
            n_tests++;
            assert ($onehot0({a_x3, a_w8, a_y8}) && !(a_dara && a_daro) &&
                    ((a_dv & a_dvn) == 5'd0) && (a_adv || ((a_dv | a_dvn) == 5'd0))) else begin
                n_fail++;
                $error("FAIL inv_p1: observed x3w8y8=%b dara/daro=%b%b adv=%b dv=%b dvn=%b expected one-hot0, exclusive, disjoint",
                       {a_x3, a_w8, a_y8}, a_dara, a_daro, a_adv, a_dv, a_dvn);
            end
            n_tests++;
            assert ($onehot0({b_x3, b_w8, b_y8}) && !(b_dara && b_daro) &&
                    ((b_dv & b_dvn) == 5'd0) && (b_adv || ((b_dv | b_dvn) == 5'd0))) else begin
                n_fail++;
                $error("FAIL inv_p15: observed x3w8y8=%b dara/daro=%b%b adv=%b dv=%b dvn=%b expected one-hot0, exclusive, disjoint",
                       {b_x3, b_w8, b_y8}, b_dara, b_daro, b_adv, b_dv, b_dvn);
            end
            if (a_cack || a_dack) a_acks++;
            if (b_cack || b_dack) b_acks++;
            r_cpu_req  = ($urandom_range(0, 3) != 0);
            r_dca_req  = ($urandom_range(0, 3) != 0);
            r_cpu_addr = 5'($urandom);
            r_dca_addr = 5'($urandom);
            r_cpu_rd   = 1'($urandom);
            r_dca_rd   = 1'($urandom);
        end
    end

    initial begin
        // Single CPU write.
        do_reset("reset_1");
        cpu_req  = 1'b1;
        cpu_addr = 5'b00101;
        cpu_rd   = 1'b0;
        watch("cpu_wr", 1, 12, 5'b00101, 1'b0, 1'b0, 1'b0, 0, 2'b01);

        // Simultaneous requests: CPU first, DCA next, ACKs 11 cycles apart.
        do_reset("reset_2");
        cpu_req  = 1'b1;
        cpu_addr = 5'b01010;
        cpu_rd   = 1'b1;
        dca_req  = 1'b1;
        dca_addr = 5'b10001;
        dca_rd   = 1'b0;
        watch("both_cpu", 1, 11, 5'b01010, 1'b1, 1'b0, 1'b0, 0, 2'b01);
        watch("both_dca", 1, 11, 5'b10001, 1'b0, 1'b1, 1'b0, 0, 2'b10);

        // Both held for six commands: strict alternation starting with CPU.
        do_reset("reset_3");
        cpu_req  = 1'b1;
        cpu_addr = 5'b11100;
        cpu_rd   = 1'b0;
        dca_req  = 1'b1;
        dca_addr = 5'b00011;
        dca_rd   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic own;
            own = c[0];
            watch($sformatf("rr%0d", c), 1, 11, own ? 5'b00011 : 5'b11100,
                  own ? 1'b1 : 1'b0, own, (c == 0) ? 1'b0 : ~own, 0,
                  (c == 5) ? 2'b11 : 2'b00);
        end

        // DCA read with address and RD changed two cycles after ARB.
        do_reset("reset_4");
        dca_req  = 1'b1;
        dca_addr = 5'b00110;
        dca_rd   = 1'b1;
        watch("dca_rd", 1, 11, 5'b00110, 1'b1, 1'b1, 1'b0, 3, 2'b10);

        // Reset asserted in the first W8 cycle: outputs clear at once, no ACK afterwards.
        do_reset("reset_5");
        cpu_req  = 1'b1;
        cpu_addr = 5'b11001;
        cpu_rd   = 1'b0;
        watch("rst_mid", 1, 6, 5'b11001, 1'b0, 1'b0, 1'b0, 0, 2'b00);
        #2;
        rst     = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("rst_async", 20'd0);
        @(negedge clk);
        check("rst_held", 20'd0);
        rst = 1'b1;
        watch("rst_idle", 20, 24, 5'd0, 1'b0, 1'b0, 1'b0, 0, 2'b00);
        dca_req  = 1'b1;
        dca_addr = 5'b01011;
        dca_rd   = 1'b0;
        watch("post_rst", 1, 11, 5'b01011, 1'b0, 1'b1, 1'b0, 0, 2'b10);

        // Let the random instances run long enough for ~2000 commands at PHASE_CYC=1.
        repeat (16000) @(negedge clk);
        n_tests++;
        assert (a_acks > 1000) else begin
            n_fail++;
            $error("FAIL acks_p1: observed %0d expected more than 1000", a_acks);
        end
        n_tests++;
        assert (b_acks > 100) else begin
            n_fail++;
            $error("FAIL acks_p15: observed %0d expected more than 100", b_acks);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
